// File: rtl/digits_to_score.sv
// ---------------------------------------------------------------------------
// digits_to_score
//
// Converts a packed vector of BCD digits into a binary score. Runs a
// multiply-by-ten accumulator one digit per clock, most significant digit
// first. A request containing a digit above 9 finishes at once with err set
// and a zero score.
//
// Ports:
//   clock      - system clock, rising edge
//   resetn     - synchronous active-low reset
//   start      - conversion request, sampled only while idle
//   digits_in  - packed BCD, bits [3:0] are the ones digit
//   busy       - high while a conversion is running
//   done       - one-cycle pulse when score_out/err are updated
//   err        - last accepted request held a non-decimal digit
//   score_out  - binary result, held until the next completion
// ---------------------------------------------------------------------------
module digits_to_score #(
  parameter int NUM_DIGITS = 5,
  parameter int OUT_W      = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [OUT_W-1:0]        score_out
);

  // A one-digit build still needs a one-bit index register.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_CONVERT = 1'b1;

  logic                    state;
  logic [OUT_W-1:0]        acc;
  logic [OUT_W-1:0]        acc_next;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] digits_lat;
  logic [3:0]              cur_digit;
  logic                    bad_digit;

  // Any nibble above 9 in the incoming request makes it invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Pick the latched digit addressed by idx.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_digit = digits_lat[4*i +: 4];
    end
  end

  // acc*10 built from two shifts so no multiplier is inferred.
  always_comb begin
    acc_next = (acc << 3) + (acc << 1) + OUT_W'(cur_digit);
  end

  // Control: done defaults low so it only pulses on the completing edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      score_out  <= '0;
      acc        <= '0;
      idx        <= '0;
      digits_lat <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            digits_lat <= digits_in;
            if (bad_digit) begin
              done      <= 1'b1;
              err       <= 1'b1;
              score_out <= '0;
            end else begin
              state <= ST_CONVERT;
              busy  <= 1'b1;
              err   <= 1'b0;
              acc   <= '0;
              idx   <= LAST_IDX;
            end
          end
        end
        ST_CONVERT: begin
          acc <= acc_next;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            score_out <= acc_next;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
